// File: rtl/uart_pkg.sv
// Constants and state encoding shared by the UART transmitter and receiver.
package uart_pkg;

   localparam int unsigned UART_DATA_BITS  = 8;
   localparam logic        UART_IDLE_LEVEL = 1'b1;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } uart_state_e;

   // Baud counter width; never zero so CLKS_PER_BIT=1 still gets a legal vector.
   function automatic int unsigned uart_cnt_width(input int unsigned clks);
      return (clks > 1) ? $clog2(clks) : 1;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, strobing bit_end_o on the last count.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   input  logic clear_i,
   output logic bit_end_o
);

   localparam int unsigned    CntW   = uart_cnt_width(CLKS_PER_BIT);
   localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            at_max;

   assign at_max    = (cnt_q == CntMax);
   assign bit_end_o = en_i && at_max;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i || !en_i || at_max) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 LSB-first with valid/ready byte input.
// Define UART_TX_PARITY_EN to insert a parity bit (8E1/8O1, sense set by PARITY_ODD).
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 1,
   parameter bit          PARITY_ODD   = 1'b0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [UART_DATA_BITS-1:0] data_in,
   input  logic                      tx_valid,
   output logic                      tx_ready,
   output logic                      tx,
   output logic                      tx_busy,
   output logic                      tx_done
);

   uart_state_e               state_q;
   logic [UART_DATA_BITS-1:0] shift_q;
   logic [2:0]                bit_idx_q;
   logic                      tx_q;
   logic                      ready_q;
   logic                      done_q;
   logic                      accept;
   logic                      baud_en;
   logic                      bit_end;

`ifdef UART_TX_PARITY_EN
   logic parity_q;
`else
   logic unused_parity_odd;
   assign unused_parity_odd = PARITY_ODD;
`endif

   assign accept  = tx_valid && ready_q;
   assign baud_en = (state_q != StIdle);

   uart_baud_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk_i    (clk),
      .rst_ni   (reset),
      .en_i     (baud_en),
      .clear_i  (accept),
      .bit_end_o(bit_end)
   );

   // tx_q is loaded with the level of the upcoming bit so the line changes right at the edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         shift_q   <= '0;
         bit_idx_q <= '0;
         tx_q      <= UART_IDLE_LEVEL;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               tx_q <= UART_IDLE_LEVEL;
               if (accept) begin
                  shift_q   <= data_in;
                  bit_idx_q <= '0;
                  tx_q      <= ~UART_IDLE_LEVEL;
                  ready_q   <= 1'b0;
                  state_q   <= StStart;
`ifdef UART_TX_PARITY_EN
                  parity_q  <= (^data_in) ^ PARITY_ODD;
`endif
               end
            end
            StStart: begin
               if (bit_end) begin
                  state_q <= StData;
                  tx_q    <= shift_q[0];
               end
            end
            StData: begin
               if (bit_end) begin
                  if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                     state_q <= StParity;
                     tx_q    <= parity_q;
`else
                     state_q <= StStop;
                     tx_q    <= UART_IDLE_LEVEL;
`endif
                  end else begin
                     shift_q   <= shift_q >> 1;
                     tx_q      <= shift_q[1];
                     bit_idx_q <= bit_idx_q + 3'd1;
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
               if (bit_end) begin
                  state_q <= StStop;
                  tx_q    <= UART_IDLE_LEVEL;
               end
            end
`endif
            StStop: begin
               if (bit_end) begin
                  state_q <= StIdle;
                  tx_q    <= UART_IDLE_LEVEL;
                  ready_q <= 1'b1;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= StIdle;
               tx_q    <= UART_IDLE_LEVEL;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign tx       = tx_q;
   assign tx_ready = ready_q;
   assign tx_busy  = !ready_q;
   assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (4 and 1 clocks per bit), frame decoders feeding a byte scoreboard.
module tb_uart_tx;

   localparam int CA    = 4;
   localparam int CB    = 1;
   localparam bit ODD_A = 1'b0;
   localparam bit ODD_B = 1'b1;
`ifdef UART_TX_PARITY_EN
   localparam int FL = 11;
`else
   localparam int FL = 10;
`endif
   localparam int MAXS = FL * CA;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] a_data = 8'h00, b_data = 8'h00;
   logic       a_valid = 1'b0, b_valid = 1'b0;
   logic       a_ready, a_tx, a_busy, a_done;
   logic       b_ready, b_tx, b_busy, b_done;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] a_q[$];
   logic [7:0] b_q[$];
   int         a_pos = -1, b_pos = -1;
   logic       a_s [MAXS];
   logic       b_s [MAXS];

   always #5 clk = ~clk;

   uart_tx #(.CLKS_PER_BIT(CA), .PARITY_ODD(ODD_A)) dut_a (
      .clk(clk), .reset(rst_n), .data_in(a_data), .tx_valid(a_valid),
      .tx_ready(a_ready), .tx(a_tx), .tx_busy(a_busy), .tx_done(a_done)
   );

   uart_tx #(.CLKS_PER_BIT(CB), .PARITY_ODD(ODD_B)) dut_b (
      .clk(clk), .reset(rst_n), .data_in(b_data), .tx_valid(b_valid),
      .tx_ready(b_ready), .tx(b_tx), .tx_busy(b_busy), .tx_done(b_done)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Line levels of a whole frame, start bit in bit 0.
   function automatic logic [15:0] exp_frame(input logic [7:0] b, input bit odd);
`ifdef UART_TX_PARITY_EN
      return {5'b0, 1'b1, (^b) ^ odd, b, 1'b0};
`else
      if (odd) return {6'b0, 1'b1, b, 1'b0};
      return {6'b0, 1'b1, b, 1'b0};
`endif
   endfunction

   task automatic check_frame(input string tag, input logic s [MAXS], input int c, input bit odd,
                              input logic [7:0] exp, input logic done);
      logic [15:0] bits = '0;
      logic        held = 1'b1;
      for (int i = 0; i < FL; i++) begin
         bits[i] = s[i*c];
         for (int j = 1; j < c; j++) if (s[i*c+j] !== s[i*c]) held = 1'b0;
      end
      chk({tag, "_bit_hold"}, 16'(held), 16'd1);
      chk({tag, "_frame"}, bits, exp_frame(exp, odd));
      chk({tag, "_done_pulse"}, 16'(done), 16'd1);
   endtask

   // Frame decoder for instance A.
   always @(negedge clk) begin
      logic [7:0] e;
      logic       have;
      if (!rst_n) begin
         a_pos = -1;
      end else begin
         chk("a_busy_vs_ready", 16'(a_busy), 16'(!a_ready));
         if (a_pos < 0) begin
            chk("a_done_idle", 16'(a_done), 16'd0);
            if (a_tx === 1'b0) begin
               a_s[0] = a_tx;
               a_pos = 1;
            end
         end else if (a_pos < FL*CA) begin
            a_s[a_pos] = a_tx;
            chk("a_done_in_frame", 16'(a_done), 16'd0);
            a_pos++;
         end else begin
            have = (a_q.size() != 0);
            e = have ? a_q.pop_front() : 8'h00;
            chk("a_expected_frame", 16'(have), 16'd1);
            check_frame("a", a_s, CA, ODD_A, e, a_done);
            a_pos = -1;
         end
      end
   end

   // Frame decoder for instance B.
   always @(negedge clk) begin
      logic [7:0] e;
      logic       have;
      if (!rst_n) begin
         b_pos = -1;
      end else begin
         chk("b_busy_vs_ready", 16'(b_busy), 16'(!b_ready));
         if (b_pos < 0) begin
            chk("b_done_idle", 16'(b_done), 16'd0);
            if (b_tx === 1'b0) begin
               b_s[0] = b_tx;
               b_pos = 1;
            end
         end else if (b_pos < FL*CB) begin
            b_s[b_pos] = b_tx;
            chk("b_done_in_frame", 16'(b_done), 16'd0);
            b_pos++;
         end else begin
            have = (b_q.size() != 0);
            e = have ? b_q.pop_front() : 8'h00;
            chk("b_expected_frame", 16'(have), 16'd1);
            check_frame("b", b_s, CB, ODD_B, e, b_done);
            b_pos = -1;
         end
      end
   end

   // Called just after a negedge; returns just after the negedge following the accept edge.
   task automatic send_a(input logic [7:0] b, input bit keep);
      int n = 0;
      a_data = b;
      a_valid = 1'b1;
      while (!a_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("a_accept_timeout", 16'(n < 200), 16'd1);
      a_q.push_back(b);
      @(negedge clk);
      if (!keep) a_valid = 1'b0;
   endtask

   task automatic send_b(input logic [7:0] b, input bit keep);
      int n = 0;
      b_data = b;
      b_valid = 1'b1;
      while (!b_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("b_accept_timeout", 16'(n < 200), 16'd1);
      b_q.push_back(b);
      @(negedge clk);
      if (!keep) b_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (n < 600 && !(a_pos < 0 && b_pos < 0 && a_q.size() == 0 && b_q.size() == 0
                          && a_ready && b_ready)) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", 16'(n < 600), 16'd1);
   endtask

   initial begin
      // Reset held with valid asserted: nothing may start.
      a_valid = 1'b1; a_data = 8'h55;
      b_valid = 1'b1; b_data = 8'hAA;
      #1 rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_a_tx", 16'(a_tx), 16'd1);
         chk("rst_a_ready", 16'(a_ready), 16'd1);
         chk("rst_a_busy", 16'(a_busy), 16'd0);
         chk("rst_a_done", 16'(a_done), 16'd0);
         chk("rst_b_tx", 16'(b_tx), 16'd1);
         chk("rst_b_ready", 16'(b_ready), 16'd1);
      end
      a_valid = 1'b0;
      b_valid = 1'b0;
      #2 rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_a_tx", 16'(a_tx), 16'd1);
         chk("post_rst_b_tx", 16'(b_tx), 16'd1);
      end

      // Single byte at 4 clocks per bit.
      send_a(8'hA5, 1'b0);
      wait_idle();

      // Back-to-back at 1 clock per bit with valid held high.
      send_b(8'h00, 1'b1);
      send_b(8'hFF, 1'b1);
      chk("b2b_start_after_done", 16'(b_tx), 16'd0);
      b_valid = 1'b0;
      wait_idle();

      // Input churn while a frame is in flight.
      send_a(8'h5A, 1'b0);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         a_data = 8'($urandom);
         a_valid = i[0];
         chk("a_ready_mid_frame", 16'(a_ready), 16'd0);
      end
      a_valid = 1'b0;
      wait_idle();
      repeat (12) @(negedge clk);
      chk("no_extra_frame", 16'(a_busy), 16'd0);

      // Reset during data bit 3 of 8'h3C.
      send_a(8'h3C, 1'b0);
      repeat (18) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_tx", 16'(a_tx), 16'd1);
      chk("midrst_ready", 16'(a_ready), 16'd1);
      chk("midrst_done", 16'(a_done), 16'd0);
      a_q.delete();
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("after_midrst_tx", 16'(a_tx), 16'd1);
      end
      send_a(8'h81, 1'b0);
      wait_idle();

`ifdef UART_TX_PARITY_EN
      // Even parity on A, odd on B.
      send_a(8'h07, 1'b0);
      send_b(8'h07, 1'b0);
      wait_idle();
`endif

      repeat (5) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
